spi_digit_scanner: RTL
======================

# spi_digit_scanner

Multi-digit, time-multiplexed seven-segment display stage. It sits directly downstream of the SPI slave. It consumes the 4-bit `spi_data_out` / `spi_data_valid_out` nibble stream and shifts each accepted nibble into a digit buffer. It scans the buffer onto a shared common-anode segment bus with active-low digit enables, replacing the single-digit static hex display path.

## Interface
- `NUM_DIGITS`, default 4: digits in buffer and scan; legal range 2..8.
- `REFRESH_DIV`, default 50000: clk cycles per digit slot; must be >= 2.
- `BLANK_UNUSED`, default 1: 1 = digits not yet written since reset/clear are blanked; 0 = they show `0`.
- `clk`, in, 1: single clock; all state on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `data_in`, in, 4: nibble from the SPI slave.
- `data_valid_in`, in, 1: one-cycle strobe; `data_in` is valid in this cycle.
- `clear_in`, in, 1: synchronous clear of buffer and digit count.
- `segments_out`, out, 7: active-low segments; bit0=a … bit6=g.
- `digit_en_out`, out, NUM_DIGITS: active-low digit enables, one-hot-low; bit0 = rightmost digit.
- `digit_buffer_out`, out, 4*NUM_DIGITS: raw buffer contents; digit i is at [4i+3:4i].
- `digit_count_out`, out, 4: digits written since reset/clear, saturating at NUM_DIGITS.

## Operation
- Buffer accept: on `data_valid_in`=1, buffer <= {buffer[4*NUM_DIGITS-5:0], data_in}. The newest nibble is digit 0 and older digits move left. The oldest digit is discarded once the buffer is full.
- `digit_count_out` increments on each accept until it reaches NUM_DIGITS, then holds.
- `clear_in`=1 zeroes the buffer and count. It has priority over a `data_valid_in` in the same cycle, and that nibble is dropped.
- `reset` has priority over everything.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At its terminal count, `scan_idx` advances modulo NUM_DIGITS.
- Scan sequence is 0,1,…,NUM_DIGITS-1,0,…. Data accepts and clears do not affect the prescaler or `scan_idx`.
- Digit blanking: digit i is blank when BLANK_UNUSED=1 and i >= `digit_count_out`. A blank digit drives all segments off (7'h7F); its enable is still driven low.
- Hex decode, active-high with bit0=a, before inversion: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
- `segments_out` is the bitwise inverse of the decode value.
- `digit_en_out` is registered: all ones except bit `scan_idx` = 0.
- `segments_out` is registered from the decode of digit `scan_idx` (or blank), using buffer and count as they stand at the same edge.

## Timing
- Reset values, one edge after `reset`=1:
  - buffer = 0, `digit_count_out` = 0, prescaler = 0, `scan_idx` = 0.
  - `segments_out` = 7'h7F.
  - `digit_en_out` = all ones (no digit lit).
- The first cycle after reset deasserts drives digit 0 (enable bit0 low).
- Reset asserted mid-scan or mid-stream returns every item above to its reset value at the next edge. No partial state survives.
- Accept latency:
  - A nibble strobed at edge k is in `digit_buffer_out` and `digit_count_out` after edge k.
  - If its digit is being scanned, `segments_out` reflects it after edge k+1.
- Slot length: every digit is enabled for exactly REFRESH_DIV consecutive cycles. The full frame is NUM_DIGITS*REFRESH_DIV cycles.
- `segments_out` and `digit_en_out` change on the same edge at a slot boundary.
- Back-to-back strobes on consecutive cycles are all accepted. There is no backpressure and no strobe is ever dropped, except one that coincides with `clear_in` or `reset`.
- Count saturation: the (NUM_DIGITS+1)th accept shifts the buffer but leaves the count at NUM_DIGITS.

## Test plan
- **Reset:** assert `reset` 3 cycles, then release.
  - During reset: `segments_out`=7'h7F, `digit_en_out`=4'b1111, buffer=16'h0000, count=0.
  - Cycle after release: `digit_en_out`=4'b1110 and `segments_out`=7'h7F (blank).
- **Blanking with BLANK_UNUSED=1:** strobe `data_in`=4'h3.
  - Buffer=16'h0003, count=1.
  - Digit 0 slot shows 7'h30. Digits 1–3 show 7'h7F.
- **Shift and saturation:** strobe 1,2,3,4,5 on consecutive cycles.
  - Buffer=16'h2345, count=4.
  - Scan with REFRESH_DIV=4: en 1110/seg 7'h12 (5), 1101/7'h19 (4), 1011/7'h30 (3), 0111/7'h24 (2), each for 4 cycles, then repeat.
- **Clear priority:** with buffer 16'h2345, drive `clear_in`=1 and `data_valid_in`=1 (`data_in`=4'hF) in the same cycle.
  - Buffer=0, count=0, nibble F absent.
  - Prescaler and `scan_idx` continue without a glitch.
- **Full hex decode:** strobe each value 0..F while scanning digit 0.
  - `segments_out` equals the inverse of the listed decode, e.g. A -> 7'h08, F -> 7'h0E.
- **Reset mid-frame:** assert `reset` during the digit 2 slot with a full buffer.
  - Next edge: all reset values.
  - After release: scan restarts at digit 0 with a full REFRESH_DIV slot.

Source files
------------

// File: rtl/spi_digit_scanner.sv
// Buffers SPI nibbles and time-multiplexes them onto a common-anode seven-segment bus.
// Segment and enable outputs are registered: one edge behind scan_idx and buffer state. There is no backpressure.
module spi_digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_UNUSED = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              data_in,
    input  logic                    data_valid_in,
    input  logic                    clear_in,
    output logic [6:0]              segments_out,
    output logic [NUM_DIGITS-1:0]   digit_en_out,
    output logic [4*NUM_DIGITS-1:0] digit_buffer_out,
    output logic [3:0]              digit_count_out
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);

    logic [PW-1:0]         prescale;
    logic [SW-1:0]         scan_idx;
    logic [3:0]            cur_digit;
    logic                  blank;
    logic [6:0]            decode;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] en_next;

    always_comb begin
        cur_digit = digit_buffer_out[{scan_idx, 2'b00} +: 4];
        blank     = (BLANK_UNUSED != 0) && (4'(scan_idx) >= digit_count_out);
        case (cur_digit)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
        seg_next = blank ? 7'h7F : ~decode;
        en_next  = ~(NUM_DIGITS'(1) << scan_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale         <= '0;
            scan_idx         <= '0;
            segments_out     <= 7'h7F;
            digit_en_out     <= '1;
            digit_buffer_out <= '0;
            digit_count_out  <= '0;
        end else begin
            // Scan timing is free-running; data and clear never disturb it.
            if (prescale == PW'(REFRESH_DIV - 1)) begin
                prescale <= '0;
                scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                prescale <= prescale + 1'b1;
            end
            segments_out <= seg_next;
            digit_en_out <= en_next;
            if (clear_in) begin
                digit_buffer_out <= '0;
                digit_count_out  <= '0;
            end else if (data_valid_in) begin
                digit_buffer_out <= {digit_buffer_out[4*NUM_DIGITS-5:0], data_in};
                if (digit_count_out != 4'(NUM_DIGITS))
                    digit_count_out <= digit_count_out + 1'b1;
            end
        end
    end

endmodule
